ddr_req_queue: RTL and testbench
================================

Name: ddr_req_queue

Overview:
Parametrised transaction buffer between the stimulus source and the DDR4 controller. It accepts {address, write data, op} transactions on a valid/ready push port and stores them in a DEPTH-entry FIFO. It issues each transaction, in push order, as a one-cycle act_cmd pulse whenever the device is not busy and the controller is in activate-idle. It also provides occupancy, flush, per-op issue counters and a sticky overflow flag.

Parameters:
ADDR_W, 29, physical address width
DATA_W, 64, write data width
RW_W, 2, op field width; 2'b01 = read, 2'b10 = write, other codes are passed through and counted as neither
DEPTH, 16, FIFO entries; power of 2, at least 2
CNT_W, 16, width of the issue counters

Ports:
clock_t  in  1  single clock, rising edge
reset_n  in  1  asynchronous active-low reset
push_valid  in  1  transaction offered
push_ready  out  1  FIFO can accept; equals !full
push_addr  in  ADDR_W  transaction address
push_data  in  DATA_W  transaction write data
push_rw  in  RW_W  transaction op
flush  in  1  synchronous discard of all queued entries
dev_busy  in  1  device busy; blocks issue
act_idle  in  1  controller ready for a new activate
act_cmd  out  1  one-cycle issue strobe
out_addr  out  ADDR_W  address of the last issued transaction
out_data  out  DATA_W  data of the last issued transaction
out_rw  out  RW_W  op of the last issued transaction
count  out  $clog2(DEPTH)+1  current FIFO occupancy
rd_issued  out  CNT_W  reads issued, wraps modulo 2^CNT_W
wr_issued  out  CNT_W  writes issued, wraps modulo 2^CNT_W
overflow_err  out  1  sticky: a push was attempted while full

Behaviour:
- Reset (reset_n low, asynchronous): FIFO empty, count=0, act_cmd=0, out_addr/out_data/out_rw=0, rd_issued=wr_issued=0, overflow_err=0, FSM=IDLE. Reset asserted mid-issue drops the transaction in flight and all queued entries.
- Storage: circular buffer with read/write pointers of $clog2(DEPTH) bits plus count. Pointers wrap from DEPTH-1 to 0.
  - full = (count==DEPTH); empty = (count==0).
- Push: an entry is written on an edge where push_valid && push_ready && !flush.
  - push_ready depends only on full. A pop in the same cycle does not free a slot for that cycle's push.
- Overflow: push_valid && full on an edge sets overflow_err. The entry is not stored. overflow_err is cleared only by reset.
- Issue FSM, two states:
  - IDLE: on an edge where !empty && !dev_busy && act_idle && !flush:
    - act_cmd<=1
    - out_* <= head entry
    - head is popped
    - rd_issued or wr_issued increments according to the head's op
    - FSM goes to GAP
  - GAP: act_cmd<=0 unconditionally; FSM goes to IDLE.
  - Result: act_cmd is high for exactly one cycle, with at most one issue every 2 cycles.
- Output hold: out_* change only on an issue edge and hold their value between issues.
- Latency: a push into an empty queue produces act_cmd at the earliest 1 cycle after the push edge. There is no bypass path.
- Simultaneous push and pop: count is unchanged, both pointers advance.
- Flush (synchronous): has priority over push and issue on the same edge.
  - Pointers reset, count becomes 0, act_cmd<=0, FSM goes to IDLE.
  - out_*, the issue counters and overflow_err are not affected.
- Stall: dev_busy or !act_idle in IDLE holds the FSM and queue with no issue. Sampling happens only on edges.
- Counter wrap: rd_issued/wr_issued go from 2^CNT_W-1 to 0 with no flag.

Test Plan:
- Basic order: with act_idle=1, dev_busy=0, push (0x0000100,0xAAAA...,01) then (0x0000200,0x5555...,10). Required: two act_cmd pulses 2 cycles apart; out_addr shows 0x100 then 0x200; rd_issued=1, wr_issued=1; count returns to 0.
- Full/overflow: hold dev_busy=1 and push 17 entries with DEPTH=16. Required: push_ready=0 after the 16th; count=16; overflow_err=1; the 17th entry is never issued. Then release dev_busy. Required: exactly 16 pulses, addresses in push order.
- Stall: with 3 entries queued, toggle act_idle 1,0,0,1. Required: no act_cmd while act_idle=0; out_* hold their last values; issue resumes on the first edge with act_idle=1.
- Flush mid-stream: queue 5 entries, issue 2, then assert flush together with push_valid. Required: count=0; no further act_cmd; the pushed entry is discarded; rd/wr counters keep their values (2 issued).
- Reset mid-operation: assert reset_n=0 asynchronously between edges while act_cmd=1. Required: act_cmd, count and counters go to 0 immediately; after release, no issue until a new push.
- Pointer wrap: push and issue 40 transactions with DEPTH=16 and a random dev_busy pattern. Required: issue order matches push order across 2+ pointer wraps, and the final counter totals match the pushed op mix.

Source files
------------

// File: rtl/ddr_req_queue.sv
// ddr_req_queue: DEPTH-entry transaction FIFO feeding the DDR4 controller.
// Entries leave in push order as single-cycle act_cmd strobes, no more than
// one every two cycles, gated by dev_busy and act_idle. Also keeps occupancy,
// per-op issue counters and a sticky overflow flag.
module ddr_req_queue #(
  parameter int ADDR_W = 29,
  parameter int DATA_W = 64,
  parameter int RW_W   = 2,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 16
) (
  input  logic                    clock_t,
  input  logic                    reset_n,
  input  logic                    push_valid,
  output logic                    push_ready,
  input  logic [ADDR_W-1:0]       push_addr,
  input  logic [DATA_W-1:0]       push_data,
  input  logic [RW_W-1:0]         push_rw,
  input  logic                    flush,
  input  logic                    dev_busy,
  input  logic                    act_idle,
  output logic                    act_cmd,
  output logic [ADDR_W-1:0]       out_addr,
  output logic [DATA_W-1:0]       out_data,
  output logic [RW_W-1:0]         out_rw,
  output logic [$clog2(DEPTH):0]  count,
  output logic [CNT_W-1:0]        rd_issued,
  output logic [CNT_W-1:0]        wr_issued,
  output logic                    overflow_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]  DEPTH_C = (PTR_W+1)'(DEPTH);
  localparam logic [RW_W-1:0] OP_RD   = RW_W'(1);
  localparam logic [RW_W-1:0] OP_WR   = RW_W'(2);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_GAP  = 1'b1
  } state_e;

  logic [ADDR_W-1:0] addr_mem_q [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];
  logic [RW_W-1:0]   rw_mem_q   [DEPTH];

  state_e            state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              act_cmd_q, act_cmd_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [RW_W-1:0]   out_rw_q, out_rw_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic              ovf_q, ovf_d;

  logic full_s;
  logic empty_s;
  logic push_fire_s;
  logic issue_s;

  // Handshake and issue qualifiers derived from registered occupancy only,
  // so a same-cycle pop never opens a slot for that cycle's push.
  always_comb begin
    full_s      = (count_q == DEPTH_C);
    empty_s     = (count_q == '0);
    push_fire_s = push_valid && !full_s && !flush;
    issue_s     = (state_q == ST_IDLE) && !empty_s && !dev_busy && act_idle && !flush;
  end

  // Entry storage; no reset needed because occupancy decides what is valid.
  always_ff @(posedge clock_t) begin
    if (push_fire_s) begin
      addr_mem_q[wr_ptr_q] <= push_addr;
      data_mem_q[wr_ptr_q] <= push_data;
      rw_mem_q[wr_ptr_q]   <= push_rw;
    end
  end

  // Next-state logic for pointers, occupancy, issue FSM, outputs and counters.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    act_cmd_d  = 1'b0;
    out_addr_d = out_addr_q;
    out_data_d = out_data_q;
    out_rw_d   = out_rw_q;
    rd_cnt_d   = rd_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    ovf_d      = ovf_q | (push_valid & full_s);

    if (flush) begin
      state_d  = ST_IDLE;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (issue_s) begin
            state_d    = ST_GAP;
            act_cmd_d  = 1'b1;
            out_addr_d = addr_mem_q[rd_ptr_q];
            out_data_d = data_mem_q[rd_ptr_q];
            out_rw_d   = rw_mem_q[rd_ptr_q];
            rd_ptr_d   = rd_ptr_q + PTR_W'(1);
            case (rw_mem_q[rd_ptr_q])
              OP_RD:   rd_cnt_d = rd_cnt_q + CNT_W'(1);
              OP_WR:   wr_cnt_d = wr_cnt_q + CNT_W'(1);
              default: ;
            endcase
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_GAP:  state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase

      if (push_fire_s) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end

      case ({push_fire_s, issue_s})
        2'b10:   count_d = count_q + (PTR_W+1)'(1);
        2'b01:   count_d = count_q - (PTR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State and output registers; reset drops everything queued or in flight.
  always_ff @(posedge clock_t or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      act_cmd_q  <= 1'b0;
      out_addr_q <= '0;
      out_data_q <= '0;
      out_rw_q   <= '0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      act_cmd_q  <= act_cmd_d;
      out_addr_q <= out_addr_d;
      out_data_q <= out_data_d;
      out_rw_q   <= out_rw_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  assign push_ready   = !full_s;
  assign act_cmd      = act_cmd_q;
  assign out_addr     = out_addr_q;
  assign out_data     = out_data_q;
  assign out_rw       = out_rw_q;
  assign count        = count_q;
  assign rd_issued    = rd_cnt_q;
  assign wr_issued    = wr_cnt_q;
  assign overflow_err = ovf_q;

endmodule

// File: tb/tb_ddr_req_queue.sv
// Testbench for ddr_req_queue: transaction-level queue model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_ddr_req_queue;
  localparam int ADDR_W = 29;
  localparam int DATA_W = 64;
  localparam int RW_W   = 2;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 4;   // small so counter wrap is reachable
  localparam int CMASK  = (1 << CNT_W) - 1;

  logic              clock_t = 1'b0;
  logic              reset_n = 1'b0;
  logic              push_valid = 1'b0;
  logic              push_ready;
  logic [ADDR_W-1:0] push_addr = '0;
  logic [DATA_W-1:0] push_data = '0;
  logic [RW_W-1:0]   push_rw = '0;
  logic              flush = 1'b0;
  logic              dev_busy = 1'b0;
  logic              act_idle = 1'b0;
  logic              act_cmd;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;
  logic [RW_W-1:0]   out_rw;
  logic [$clog2(DEPTH):0] count;
  logic [CNT_W-1:0]  rd_issued;
  logic [CNT_W-1:0]  wr_issued;
  logic              overflow_err;

  ddr_req_queue #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RW_W(RW_W),
                  .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock_t(clock_t), .reset_n(reset_n), .push_valid(push_valid),
    .push_ready(push_ready), .push_addr(push_addr), .push_data(push_data),
    .push_rw(push_rw), .flush(flush), .dev_busy(dev_busy), .act_idle(act_idle),
    .act_cmd(act_cmd), .out_addr(out_addr), .out_data(out_data), .out_rw(out_rw),
    .count(count), .rd_issued(rd_issued), .wr_issued(wr_issued),
    .overflow_err(overflow_err)
  );

  always #5 clock_t = ~clock_t;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic [RW_W-1:0]   rw;
  } txn_t;

  // Model state
  txn_t mq[$];
  txn_t acc_q[$];
  txn_t m_out = '{a: '0, d: '0, rw: '0};
  int   m_rd = 0, m_wr = 0;
  bit   m_act = 1'b0, m_ovf = 1'b0;
  int   cyc = 0, last_iss = -10;

  int vectors = 0, miscompares = 0;
  bit chk_en = 1'b0;
  int pulses = 0;
  logic [ADDR_W-1:0] pulse_addr[$];
  int pulse_cyc[$];

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference model: an ordered list of pending transactions; an issue may
  // happen only if the previous issue was at least two edges ago.
  initial forever begin
    @(posedge clock_t or negedge reset_n);
    if (!reset_n) begin
      mq.delete();
      m_rd = 0; m_wr = 0; m_act = 1'b0; m_ovf = 1'b0;
      m_out = '{a: '0, d: '0, rw: '0};
      last_iss = -10;
    end else if (clock_t) begin
      bit was_full;
      cyc++;
      was_full = (mq.size() == DEPTH);
      if (push_valid && was_full) m_ovf = 1'b1;
      m_act = 1'b0;
      if (flush) begin
        mq.delete();
      end else begin
        if ((cyc - last_iss) >= 2 && mq.size() > 0 && !dev_busy && act_idle) begin
          m_out = mq.pop_front();
          m_act = 1'b1;
          last_iss = cyc;
          if (m_out.rw == 2'b01) m_rd = (m_rd + 1) & CMASK;
          if (m_out.rw == 2'b10) m_wr = (m_wr + 1) & CMASK;
        end
        if (push_valid && !was_full) begin
          mq.push_back('{a: push_addr, d: push_data, rw: push_rw});
          acc_q.push_back('{a: push_addr, d: push_data, rw: push_rw});
        end
      end
    end
  end

  // Per-cycle comparison against the model, plus pulse recording.
  initial forever begin
    @(negedge clock_t);
    if (reset_n && chk_en) begin
      chk("act_cmd",      64'(act_cmd),      64'(m_act));
      chk("out_addr",     64'(out_addr),     64'(m_out.a));
      chk("out_data",     64'(out_data),     64'(m_out.d));
      chk("out_rw",       64'(out_rw),       64'(m_out.rw));
      chk("count",        64'(count),        64'(mq.size()));
      chk("push_ready",   64'(push_ready),   64'(mq.size() != DEPTH));
      chk("rd_issued",    64'(rd_issued),    64'(m_rd));
      chk("wr_issued",    64'(wr_issued),    64'(m_wr));
      chk("overflow_err", 64'(overflow_err), 64'(m_ovf));
      if (act_cmd) begin
        pulses++;
        pulse_addr.push_back(out_addr);
        pulse_cyc.push_back(cyc);
      end
    end
  end

  task automatic step(bit pv, logic [ADDR_W-1:0] a, logic [DATA_W-1:0] d,
                      logic [RW_W-1:0] rw, bit fl, bit busy, bit idle);
    @(posedge clock_t);
    #2;
    push_valid = pv; push_addr = a; push_data = d; push_rw = rw;
    flush = fl; dev_busy = busy; act_idle = idle;
  endtask

  task automatic idle_n(int n, bit busy, bit idle);
    repeat (n) step(1'b0, '0, '0, '0, 1'b0, busy, idle);
  endtask

  task automatic do_reset();
    @(posedge clock_t);
    #2;
    reset_n = 1'b0;
    push_valid = 1'b0; flush = 1'b0; dev_busy = 1'b0; act_idle = 1'b0;
    @(posedge clock_t);
    #2;
    reset_n = 1'b1;
    pulses = 0;
    pulse_addr.delete();
    pulse_cyc.delete();
    acc_q.delete();
  endtask

  initial begin
    int p0, k, exp_rd, exp_wr;
    do_reset();
    chk_en = 1'b1;
    #1;
    chk("reset_count",   64'(count),        64'd0);
    chk("reset_act",     64'(act_cmd),      64'd0);
    chk("reset_ovf",     64'(overflow_err), 64'd0);
    chk("reset_rdcnt",   64'(rd_issued),    64'd0);

    // Basic order
    step(1'b1, 29'h100, {4{16'hAAAA}}, 2'b01, 1'b0, 1'b0, 1'b1);
    step(1'b1, 29'h200, {4{16'h5555}}, 2'b10, 1'b0, 1'b0, 1'b1);
    idle_n(6, 1'b0, 1'b1);
    chk("basic_pulses", 64'(pulses), 64'd2);
    if (pulses >= 2) begin
      chk("basic_spacing", 64'(pulse_cyc[1] - pulse_cyc[0]), 64'd2);
      chk("basic_addr0",   64'(pulse_addr[0]), 64'h100);
      chk("basic_addr1",   64'(pulse_addr[1]), 64'h200);
    end
    chk("basic_data",  out_data, {4{16'h5555}});
    chk("basic_rd",    64'(rd_issued), 64'd1);
    chk("basic_wr",    64'(wr_issued), 64'd1);
    chk("basic_count", 64'(count), 64'd0);

    // Full / overflow; 16 writes also wrap the 4-bit write counter to 0
    do_reset();
    for (int i = 0; i < 17; i++)
      step(1'b1, ADDR_W'(32'h1000 + i), {$urandom, $urandom}, 2'b10, 1'b0, 1'b1, 1'b1);
    idle_n(2, 1'b1, 1'b1);
    chk("full_count", 64'(count), 64'd16);
    chk("full_ready", 64'(push_ready), 64'd0);
    chk("full_ovf",   64'(overflow_err), 64'd1);
    chk("full_nopulse", 64'(pulses), 64'd0);
    idle_n(45, 1'b0, 1'b1);
    chk("drain_pulses", 64'(pulses), 64'd16);
    for (int i = 0; i < 16 && i < pulse_addr.size(); i++)
      chk("drain_order", 64'(pulse_addr[i]), 64'(32'h1000 + i));
    chk("wr_wrap", 64'(wr_issued), 64'd0);
    chk("ovf_sticky", 64'(overflow_err), 64'd1);

    // Stall on act_idle 1,0,0,1
    do_reset();
    for (int i = 0; i < 3; i++)
      step(1'b1, ADDR_W'(32'h300 + i), {$urandom, $urandom}, 2'b01, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
    idle_n(2, 1'b0, 1'b0);
    chk("stall_pulses", 64'(pulses), 64'd2);
    if (pulses >= 2) chk("stall_resume", 64'(pulse_cyc[1] - pulse_cyc[0]), 64'd3);
    chk("stall_hold", 64'(out_addr), 64'h301);
    chk("stall_count", 64'(count), 64'd1);
    idle_n(4, 1'b0, 1'b1);
    chk("stall_done", 64'(pulses), 64'd3);

    // Flush mid-stream together with a push
    do_reset();
    for (int i = 0; i < 5; i++)
      step(1'b1, ADDR_W'(32'h500 + i), {$urandom, $urandom}, (i % 2 == 0) ? 2'b01 : 2'b10,
           1'b0, 1'b0, 1'b0);
    idle_n(3, 1'b0, 1'b1);
    step(1'b1, 29'h5FF, {$urandom, $urandom}, 2'b01, 1'b1, 1'b0, 1'b1);
    idle_n(10, 1'b0, 1'b1);
    chk("flush_count",  64'(count), 64'd0);
    chk("flush_pulses", 64'(pulses), 64'd2);
    chk("flush_rd",     64'(rd_issued), 64'd1);
    chk("flush_wr",     64'(wr_issued), 64'd1);
    chk("flush_hold",   64'(out_addr), 64'h501);

    // Asynchronous reset while act_cmd is high
    do_reset();
    step(1'b1, 29'h700, {$urandom, $urandom}, 2'b01, 1'b0, 1'b1, 1'b1);
    step(1'b1, 29'h701, {$urandom, $urandom}, 2'b10, 1'b0, 1'b1, 1'b1);
    step(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
    k = 0;
    while (!act_cmd && k < 10) begin
      @(posedge clock_t);
      #2;
      k++;
    end
    chk("rst_act_seen", 64'(act_cmd), 64'd1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("rst_act",   64'(act_cmd), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_rd",    64'(rd_issued), 64'd0);
    chk("rst_addr",  64'(out_addr), 64'd0);
    @(posedge clock_t);
    #2;
    reset_n = 1'b1;
    p0 = pulses;
    idle_n(8, 1'b0, 1'b1);
    chk("rst_noissue", 64'(pulses - p0), 64'd0);
    chk("rst_empty",   64'(count), 64'd0);

    // Pointer wrap: 40+ transactions with random dev_busy
    do_reset();
    k = 0;
    while (acc_q.size() < 40 && k < 3000) begin
      step(($urandom % 4) != 0, ADDR_W'($urandom), {$urandom, $urandom},
           RW_W'($urandom), 1'b0, $urandom % 2, 1'b1);
      k++;
    end
    chk("wrap_accepted", 64'(acc_q.size() >= 40), 64'd1);
    idle_n(120, 1'b0, 1'b1);
    chk("wrap_pulses", 64'(pulses), 64'(acc_q.size()));
    exp_rd = 0; exp_wr = 0;
    for (int i = 0; i < acc_q.size(); i++) begin
      if (acc_q[i].rw == 2'b01) exp_rd++;
      if (acc_q[i].rw == 2'b10) exp_wr++;
      if (i < pulse_addr.size()) chk("wrap_order", 64'(pulse_addr[i]), 64'(acc_q[i].a));
    end
    chk("wrap_rd_total", 64'(rd_issued), 64'(exp_rd & CMASK));
    chk("wrap_wr_total", 64'(wr_issued), 64'(exp_wr & CMASK));

    // Random soak including flush, overflow and stalls
    for (int i = 0; i < 400; i++)
      step($urandom % 2, ADDR_W'($urandom), {$urandom, $urandom}, RW_W'($urandom),
           ($urandom % 16) == 0, ($urandom % 3) == 0, ($urandom % 4) != 0);
    idle_n(50, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
